// File: rtl/div.sv
// rtl/div.sv - radix-2 restoring 32-bit divider, signed/unsigned, one quotient bit per clock
// Optional feature macro: DIV_FAST_ZERO_EN (divide-by-zero completes on the start edge)
module div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             start,
  input  logic             signed_ope,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] part;
  logic             neg_dvd, neg_dsr, dsr_zero;

  logic             in_neg_dvd, in_neg_dsr, fast_zero;
  logic [WIDTH-1:0] in_dvd_mag, in_dsr_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign in_neg_dvd = signed_ope & dividend[WIDTH-1];
  assign in_neg_dsr = signed_ope & divisor[WIDTH-1];
  assign in_dvd_mag = in_neg_dvd ? -dividend : dividend;
  assign in_dsr_mag = in_neg_dsr ? -divisor : divisor;

`ifdef DIV_FAST_ZERO_EN
  assign fast_zero = (divisor == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // Low bits of the difference are exact modulo 2^WIDTH; the borrow needs the full 33-bit compare.
  assign shifted = {part, dvd_q[WIDTH-1]};
  assign borrow  = (shifted < {1'b0, dsr_mag});
  assign diff    = shifted[WIDTH-1:0] - dsr_mag;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && !fast_zero) state_nx = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt       <= '0;
      dvd_q     <= '0;
      dsr_mag   <= '0;
      part      <= '0;
      neg_dvd   <= 1'b0;
      neg_dsr   <= 1'b0;
      dsr_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ready     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (fast_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              neg_dvd  <= in_neg_dvd;
              neg_dsr  <= in_neg_dsr;
              dsr_zero <= (divisor == '0);
              dvd_q    <= in_dvd_mag;
              dsr_mag  <= in_dsr_mag;
              part     <= '0;
              cnt      <= '0;
              ready    <= 1'b0;
            end
          end
        end
        RUN: begin
          part  <= borrow ? shifted[WIDTH-1:0] : diff;
          dvd_q <= {dvd_q[WIDTH-2:0], ~borrow};
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          // With a zero divisor the partial remainder ends as the dividend magnitude,
          // so the normal sign fix-up restores the original dividend; only the quotient needs overriding.
          quotient  <= dsr_zero ? '1 : ((neg_dvd ^ neg_dsr) ? -dvd_q : dvd_q);
          remainder <= neg_dvd ? -part : part;
          ready     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - scoreboard testbench for div (honours DIV_FAST_ZERO_EN when defined)
module tb_div;

  logic        clk;
  logic        nrst;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        start;
  logic        signed_ope;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;

  logic [63:0] sb_q[$];
  int          n_pass;
  int          n_total;

  div #(.WIDTH(32)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .dividend   (dividend),
    .divisor    (divisor),
    .start      (start),
    .signed_ope (signed_ope),
    .quotient   (quotient),
    .remainder  (remainder),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa;
    int sbv;
    sa  = a;
    sbv = b;
    if (b == 32'h0) return {32'hFFFFFFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
    return {32'(sa / sbv), 32'(sa % sbv)};
  endfunction

  // poke: negedge index at which a spurious start is raised; abort: negedge index at which reset hits
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int poke, input int abort, input string tag);
    int          lat;
    int          lat_exp;
    logic        fast;
    logic        aborted;
    logic [63:0] exp;
`ifdef DIV_FAST_ZERO_EN
    fast = (b == 32'h0);
`else
    fast = 1'b0;
`endif
    lat_exp = fast ? 0 : 33;
    aborted = 1'b0;
    if (abort < 0) sb_q.push_back(model(a, b, s));
    @(negedge clk);
    dividend = a; divisor = b; signed_ope = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_ope = $urandom_range(0, 1);
    check({tag, "_busy"}, {63'b0, ready}, {63'b0, fast});
    lat = 0;
    while (!ready && lat < 100) begin
      @(negedge clk);
      lat++;
      start = (lat == poke);
      if (lat == abort) begin
        nrst = 1'b0;
        #1;
        check({tag, "_rst_ready"}, {63'b0, ready}, 64'd1);
        check({tag, "_rst_q"}, {32'b0, quotient}, 64'd0);
        check({tag, "_rst_r"}, {32'b0, remainder}, 64'd0);
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      nrst = 1'b1;
    end else begin
      check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
      if (sb_q.size() == 0) check({tag, "_sb_empty"}, 64'd1, 64'd0);
      else begin
        exp = sb_q.pop_front();
        check({tag, "_res"}, {quotient, remainder}, exp);
      end
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    nrst = 1'b0; start = 1'b0; dividend = '0; divisor = '0; signed_ope = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", {63'b0, ready}, 64'd1);
    check("reset_q", {32'b0, quotient}, 64'd0);
    check("reset_r", {32'b0, remainder}, 64'd0);
    nrst = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, -1, -1, "u100_7");
    check("u100_7_const", {quotient, remainder}, {32'd14, 32'd2});
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, -1, -1, "s_m7_2");
    check("s_m7_2_const", {quotient, remainder}, {32'hFFFFFFFD, 32'hFFFFFFFF});
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, -1, -1, "s_7_m2");
    check("s_7_m2_const", {quotient, remainder}, {32'hFFFFFFFD, 32'd1});
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, -1, -1, "u_max_1");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, -1, "s_ovf");
    check("s_ovf_const", {quotient, remainder}, {32'h80000000, 32'h0});
    run_op(32'h12345678, 32'd0, 1'b0, -1, -1, "u_dz");
    run_op(32'h12345678, 32'd0, 1'b1, -1, -1, "s_dz");
    check("s_dz_const", {quotient, remainder}, {32'hFFFFFFFF, 32'h12345678});
    run_op(32'h87654321, 32'd0, 1'b1, -1, -1, "s_dz_neg");
    run_op(32'd1000, 32'd3, 1'b0, 9, -1, "ignored_start");
    run_op(32'd55, 32'd5, 1'b0, -1, 15, "abort");
    run_op(32'd123456, 32'hFFFFFCEB, 1'b1, -1, -1, "post_rst");

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (i % 3 == 0) b = -b;
      run_op(a, b, 1'(i % 2), -1, -1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
